// File: rtl/jt51_slot_wr.sv
// jt51_slot_wr
//   Write injector placed directly in front of a per-slot shift-register delay
//   line. The line's output is normally fed straight back to its input; CPU-side
//   register writes are held until their target slot comes round and are then
//   substituted into the ring for exactly one cen strobe.
//
//   Build option: define JT51_SLOT_WR_FIFO_EN to hold up to QDEPTH pending
//   writes in a FIFO. Without it a single holding register is used and QDEPTH
//   is ignored.
//
// Ports
//   clk        system clock
//   rst        asynchronous, active-high reset
//   cen        slot-advance enable (same strobe as the delay line)
//   sh_drop    delay-line output, this slot's value from one frame ago
//   sh_din     delay-line input
//   slot       current slot number, 0..STAGES-1
//   slot_zero  high while slot == 0
//   wr_valid   write request valid
//   wr_ready   a write can be accepted this cycle
//   wr_slot    target slot of the write
//   wr_data    value to insert
//   wr_ack     one-clk pulse after a write is committed into the ring
//   wr_err     one-clk pulse after an accepted write targeted slot >= STAGES
module jt51_slot_wr #(
  parameter int WIDTH  = 5,
  parameter int STAGES = 32,
  parameter int QDEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cen,
  input  logic [WIDTH-1:0] sh_drop,
  output logic [WIDTH-1:0] sh_din,
  output logic [4:0]       slot,
  output logic             slot_zero,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [4:0]       wr_slot,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_ack,
  output logic             wr_err
);

  localparam logic [4:0] SLOT_LAST = 5'(STAGES - 1);
  localparam logic [5:0] SLOT_LIM  = 6'(STAGES);

  logic [4:0]       slot_q, slot_d;
  logic             rdy_en_q;
  logic             ack_q;
  logic             err_q;
  logic             xfer, bad_slot, push, pop, hit;
  logic             q_empty, q_full;
  logic [4:0]       head_slot;
  logic [WIDTH-1:0] head_data;

  // Out-of-range targets are consumed by the handshake but never queued.
  assign bad_slot  = {1'b0, wr_slot} >= SLOT_LIM;
  assign wr_ready  = rdy_en_q && !q_full;
  assign xfer      = wr_valid && wr_ready;
  assign push      = xfer && !bad_slot;
  assign hit       = !q_empty && (head_slot == slot_q);
  assign pop       = cen && hit;
  assign sh_din    = hit ? head_data : sh_drop;
  assign slot      = slot_q;
  assign slot_zero = (slot_q == 5'd0);
  assign wr_ack    = ack_q;
  assign wr_err    = err_q;

  always_comb begin
    slot_d = slot_q;
    if (cen) slot_d = (slot_q == SLOT_LAST) ? 5'd0 : slot_q + 5'd1;
  end

  // rdy_en_q keeps wr_ready low until the first clock after reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q   <= 5'd0;
      rdy_en_q <= 1'b0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      slot_q   <= slot_d;
      rdy_en_q <= 1'b1;
      ack_q    <= pop;
      err_q    <= xfer && bad_slot;
    end
  end

`ifdef JT51_SLOT_WR_FIFO_EN
  localparam int            AW      = $clog2(QDEPTH);
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0]   CNT_ONE = 1;
  localparam logic [AW:0]   CNT_MAX = (AW+1)'(QDEPTH);

  logic [4:0]       fifo_slot_q [QDEPTH];
  logic [WIDTH-1:0] fifo_data_q [QDEPTH];
  logic [AW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [AW:0]      cnt_q, cnt_d;

  assign q_empty   = (cnt_q == '0);
  assign q_full    = (cnt_q == CNT_MAX);
  assign head_slot = fifo_slot_q[rd_ptr_q];
  assign head_data = fifo_data_q[rd_ptr_q];

  // When full, wr_ready is low, so a pop never coincides with a push there.
  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + CNT_ONE;
    else if (pop && !push) cnt_d = cnt_q - CNT_ONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_slot_q[wr_ptr_q] <= wr_slot;
      fifo_data_q[wr_ptr_q] <= wr_data;
    end
  end
`else
  logic             pend_q;
  logic [4:0]       hold_slot_q;
  logic [WIDTH-1:0] hold_data_q;
  logic             unused_qdepth;

  assign unused_qdepth = (QDEPTH != 0);
  assign q_empty       = !pend_q;
  assign q_full        = pend_q;
  assign head_slot     = hold_slot_q;
  assign head_data     = hold_data_q;

  // push requires !pend_q, so push and pop are mutually exclusive here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       pend_q <= 1'b0;
    else if (push) pend_q <= 1'b1;
    else if (pop)  pend_q <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      hold_slot_q <= wr_slot;
      hold_data_q <= wr_data;
    end
  end
`endif

endmodule

// File: tb/tb_jt51_slot_wr.sv
// Bench for jt51_slot_wr: a shift-register delay line closes the ring, and a
// queue-based reference model predicts slot, sh_din, wr_ready, wr_ack, wr_err.
// A second instance with STAGES=24 exercises the out-of-range write path.
module tb_jt51_slot_wr;
  localparam int W  = 5;
  localparam int ST = 32;
  localparam int QD = 4;
`ifdef JT51_SLOT_WR_FIFO_EN
  localparam int CAP = QD;
`else
  localparam int CAP = 1;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cen = 1'b0;
  logic         wr_valid = 1'b0;
  logic [4:0]   wr_slot = '0;
  logic [W-1:0] wr_data = '0;
  logic [W-1:0] sh_drop, sh_din;
  logic [4:0]   slot;
  logic         slot_zero, wr_ready, wr_ack, wr_err;

  logic         e_cen = 1'b1;
  logic         e_valid = 1'b0;
  logic [4:0]   e_wslot = '0;
  logic [W-1:0] e_wdata = '0;
  logic [W-1:0] e_drop = '0;
  logic [W-1:0] e_din;
  logic [4:0]   e_slot_o;
  logic         e_zero, e_ready, e_ack, e_err;

  always #5 clk = ~clk;

  jt51_slot_wr #(.WIDTH(W), .STAGES(ST), .QDEPTH(QD)) dut (
    .clk(clk), .rst(rst), .cen(cen), .sh_drop(sh_drop), .sh_din(sh_din),
    .slot(slot), .slot_zero(slot_zero), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_slot(wr_slot), .wr_data(wr_data), .wr_ack(wr_ack), .wr_err(wr_err));

  jt51_slot_wr #(.WIDTH(W), .STAGES(24), .QDEPTH(QD)) u_err (
    .clk(clk), .rst(rst), .cen(e_cen), .sh_drop(e_drop), .sh_din(e_din),
    .slot(e_slot_o), .slot_zero(e_zero), .wr_valid(e_valid), .wr_ready(e_ready),
    .wr_slot(e_wslot), .wr_data(e_wdata), .wr_ack(e_ack), .wr_err(e_err));

  // delay line closing the ring
  logic            preload = 1'b0;
  logic [ST*W-1:0] preload_val = '0;
  logic [ST*W-1:0] line_q;
  always @(posedge clk) begin
    if (preload)  line_q <= preload_val;
    else if (cen) line_q <= {line_q[ST*W-W-1:0], sh_din};
  end
  assign sh_drop = line_q[ST*W-1 -: W];

  // reference model
  typedef struct packed { logic [4:0] s; logic [W-1:0] d; } wr_t;
  wr_t  q[$];
  int   m_slot = 0;
  bit   m_rdy = 1'b0, m_ack = 1'b0, m_err = 1'b0;
  logic [13:0] want;
  logic [13:0] got;
  int   checks = 0, errors = 0;

  assign got = {slot, slot_zero, sh_din, wr_ready, wr_ack, wr_err};

  function automatic bit ready_now();
    return m_rdy && (q.size() < CAP);
  endfunction

  // Fills 'want' for the current cycle, then advances to the post-edge state.
  task automatic model_tick();
    bit hit, xfer;
    logic [W-1:0] din;
    if (rst) begin
      q.delete(); m_slot = 0; m_rdy = 1'b0; m_ack = 1'b0; m_err = 1'b0;
    end
    hit  = (q.size() > 0) && (q[0].s == 5'(m_slot));
    din  = hit ? q[0].d : sh_drop;
    want = {5'(m_slot), 1'(m_slot == 0), din, ready_now(), m_ack, m_err};
    if (!rst) begin
      xfer  = wr_valid && ready_now();
      m_ack = cen && hit;
      m_err = xfer && (int'(wr_slot) >= ST);
      if (cen && hit) void'(q.pop_front());
      if (xfer && int'(wr_slot) < ST) q.push_back(wr_t'{s: wr_slot, d: wr_data});
      if (cen) m_slot = (m_slot + 1) % ST;
      m_rdy = 1'b1;
    end
  endtask

  task automatic step();
    @(negedge clk);
    model_tick();
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int zeros = 0;
    rst = 1'b1; cen = 1'b0; wr_valid = 1'b0;
    preload_val = {$urandom, $urandom, $urandom, $urandom, $urandom};
    preload = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (got !== want) begin errors++; $display("FAIL reset: got=%h want=%h", got, want); end
      nxt();
    end
    preload = 1'b0;
    rst = 1'b0;
    step();
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL ready_first_clk: got=%b want=0", wr_ready); end
    nxt();
    step();
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL ready_after_release: got=%b want=1", wr_ready); end
    nxt();
    cen = 1'b1;
    for (int i = 0; i < 64; i++) begin
      step();
      checks++; if (got !== want) begin errors++; $display("FAIL idle_ring: got=%h want=%h", got, want); end
      if (i < 32 && slot_zero) zeros++;
      nxt();
    end
    checks++; if (zeros != 1) begin errors++; $display("FAIL slot_zero_count: got=%0d want=1", zeros); end
  endtask

  task automatic test_single();
    int acks = 0, seen = 0;
    logic [4:0] prev = '0;
    cen = 1'b1;
    for (int i = 0; i < 64 && m_slot != 3; i++) begin
      step();
      checks++; if (got !== want) begin errors++; $display("FAIL single_wait: got=%h want=%h", got, want); end
      nxt();
    end
    wr_valid = 1'b1; wr_slot = 5'd7; wr_data = 5'h15;
    step();
    checks++; if (got !== want) begin errors++; $display("FAIL single_accept: got=%h want=%h", got, want); end
    nxt();
    wr_valid = 1'b0;
    for (int i = 0; i < 70; i++) begin
      step();
      checks++; if (got !== want) begin errors++; $display("FAIL single: got=%h want=%h", got, want); end
      if (wr_ack) begin
        acks++;
        checks++; if (prev !== 5'd7) begin errors++; $display("FAIL single_ack_slot: got=%0d want=7", prev); end
      end else if (acks == 1 && slot == 5'd7) begin
        seen++;
        checks++; if (sh_drop !== 5'h15) begin errors++; $display("FAIL single_ring: got=%h want=15", sh_drop); end
      end
      prev = slot;
      nxt();
    end
    checks++; if (acks != 1 || seen == 0) begin errors++; $display("FAIL single_counts: acks=%0d seen=%0d want 1 and >0", acks, seen); end
  endtask

  task automatic test_wrap();
    int at = -1;
    cen = 1'b1;
    for (int i = 0; i < 64 && m_slot != 0; i++) begin
      step();
      checks++; if (got !== want) begin errors++; $display("FAIL wrap_wait: got=%h want=%h", got, want); end
      nxt();
    end
    wr_valid = 1'b1; wr_slot = 5'd31; wr_data = 5'($urandom);
    step();
    checks++; if (got !== want) begin errors++; $display("FAIL wrap_accept: got=%h want=%h", got, want); end
    nxt();
    wr_valid = 1'b0;
    for (int i = 0; i < 40 && at < 0; i++) begin
      step();
      checks++; if (got !== want) begin errors++; $display("FAIL wrap31: got=%h want=%h", got, want); end
      if (wr_ack) at = i;
      nxt();
    end
    checks++; if (at != 31) begin errors++; $display("FAIL wrap31_latency: got=%0d want=31", at); end
    for (int i = 0; i < 64 && !(m_slot == 31 && ready_now()); i++) begin
      step();
      checks++; if (got !== want) begin errors++; $display("FAIL wrap_wait2: got=%h want=%h", got, want); end
      nxt();
    end
    wr_valid = 1'b1; wr_slot = 5'd0; wr_data = 5'($urandom);
    step();
    checks++; if (got !== want) begin errors++; $display("FAIL wrap0_accept: got=%h want=%h", got, want); end
    nxt();
    wr_valid = 1'b0;
    at = -1;
    for (int i = 0; i < 40 && at < 0; i++) begin
      step();
      checks++; if (got !== want) begin errors++; $display("FAIL wrap0: got=%h want=%h", got, want); end
      if (wr_ack) at = i;
      nxt();
    end
    checks++; if (at != 1) begin errors++; $display("FAIL wrap0_latency: got=%0d want=1", at); end
  endtask

  task automatic test_hold();
    logic [W-1:0] d;
    int bad = 0;
    d = 5'($urandom);
    cen = 1'b1;
    for (int i = 0; i < 64 && m_slot != 1; i++) begin
      step();
      checks++; if (got !== want) begin errors++; $display("FAIL hold_wait: got=%h want=%h", got, want); end
      nxt();
    end
    wr_valid = 1'b1; wr_slot = 5'd4; wr_data = d;
    step();
    checks++; if (got !== want) begin errors++; $display("FAIL hold_accept: got=%h want=%h", got, want); end
    nxt();
    wr_valid = 1'b0;
    for (int i = 0; i < 64 && m_slot != 4; i++) begin
      step();
      checks++; if (got !== want) begin errors++; $display("FAIL hold_wait4: got=%h want=%h", got, want); end
      nxt();
    end
    cen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++; if (got !== want) begin errors++; $display("FAIL hold: got=%h want=%h", got, want); end
      if (sh_din !== d || wr_ack !== 1'b0) bad++;
      nxt();
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL hold_din: bad cycles=%0d want 0", bad); end
    cen = 1'b1;
    step();
    nxt();
    step();
    checks++; if (wr_ack !== 1'b1) begin errors++; $display("FAIL hold_commit_ack: got=%b want=1", wr_ack); end
    nxt();
  endtask

  task automatic test_queue();
    int acks = 0;
    cen = 1'b1;
    for (int i = 0; i < 64 && m_slot != 0; i++) begin
      step();
      checks++; if (got !== want) begin errors++; $display("FAIL queue_wait: got=%h want=%h", got, want); end
      nxt();
    end
    cen = 1'b0;
`ifdef JT51_SLOT_WR_FIFO_EN
    begin
      int n = 0;
      logic [4:0]   ps[4] = '{5'd9, 5'd2, 5'd9, 5'd20};
      logic [W-1:0] pd[4] = '{5'd1, 5'd2, 5'd3, 5'd4};
      logic [4:0]   prev_s = '0;
      logic [W-1:0] prev_d = '0;
      for (int k = 0; k < 4; k++) begin
        wr_valid = 1'b1; wr_slot = ps[k]; wr_data = pd[k];
        step();
        checks++; if (got !== want) begin errors++; $display("FAIL fifo_push: got=%h want=%h", got, want); end
        nxt();
      end
      wr_valid = 1'b0;
      step();
      checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL fifo_full_ready: got=%b want=0", wr_ready); end
      nxt();
      cen = 1'b1;
      for (int i = 0; i < 200 && n < 3; i++) begin
        step();
        checks++; if (got !== want) begin errors++; $display("FAIL fifo_drain: got=%h want=%h", got, want); end
        if (wr_ack) begin
          checks++;
          if (prev_s !== ps[n] || prev_d !== pd[n]) begin
            errors++; $display("FAIL fifo_order: commit %0d got slot=%0d data=%h want slot=%0d data=%h", n, prev_s, prev_d, ps[n], pd[n]);
          end
          n++;
        end
        prev_s = slot; prev_d = sh_din;
        nxt();
      end
      checks++; if (n != 3) begin errors++; $display("FAIL fifo_commits: got=%0d want=3", n); end
    end
`else
    wr_valid = 1'b1; wr_slot = 5'd9; wr_data = 5'd1;
    step();
    checks++; if (got !== want) begin errors++; $display("FAIL single_push: got=%h want=%h", got, want); end
    nxt();
    wr_slot = 5'd2; wr_data = 5'd2;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL pending_ready: got=%b want=0", wr_ready); end
      nxt();
    end
    wr_valid = 1'b0;
`endif
    cen = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (got !== want) begin errors++; $display("FAIL pre_reset: got=%h want=%h", got, want); end
      nxt();
    end
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (got !== want) begin errors++; $display("FAIL mid_reset: got=%h want=%h", got, want); end
      nxt();
    end
    rst = 1'b0; cen = 1'b0;
    step();
    nxt();
    step();
    checks++; if (wr_ready !== 1'b1 || slot !== 5'd0) begin errors++; $display("FAIL post_reset: ready=%b slot=%0d want ready=1 slot=0", wr_ready, slot); end
    nxt();
    cen = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      checks++; if (got !== want) begin errors++; $display("FAIL post_reset_run: got=%h want=%h", got, want); end
      if (wr_ack) acks++;
      nxt();
    end
    checks++; if (acks != 0) begin errors++; $display("FAIL discarded_ack: got=%0d want=0", acks); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      cen      = ($urandom_range(0, 3) != 0);
      wr_valid = 1'($urandom_range(0, 1));
      wr_slot  = 5'($urandom_range(0, 31));
      wr_data  = 5'($urandom);
      step();
      checks++; if (got !== want) begin errors++; $display("FAIL random cyc %0d: got=%h want=%h", i, got, want); end
      nxt();
    end
    wr_valid = 1'b0;
  endtask

  task automatic test_err();
    e_valid = 1'b1; e_wslot = 5'd30; e_wdata = 5'h1F; e_drop = 5'($urandom);
    @(negedge clk);
    checks++; if (e_ready !== 1'b1 || e_err !== 1'b0) begin errors++; $display("FAIL err_pre: ready=%b err=%b want 1 0", e_ready, e_err); end
    nxt();
    e_valid = 1'b0;
    @(negedge clk);
    checks++; if (e_err !== 1'b1) begin errors++; $display("FAIL err_pulse: got=%b want=1", e_err); end
    nxt();
    for (int i = 0; i < 30; i++) begin
      e_drop = 5'($urandom);
      @(negedge clk);
      checks++;
      if ({e_err, e_ack, e_ready, e_din} !== {1'b0, 1'b0, 1'b1, e_drop} || e_slot_o >= 5'd24 || e_zero !== (e_slot_o == 5'd0)) begin
        errors++;
        $display("FAIL err_after: err=%b ack=%b ready=%b din=%h slot=%0d zero=%b want 0 0 1 din=%h slot<24", e_err, e_ack, e_ready, e_din, e_slot_o, e_zero, e_drop);
      end
      nxt();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_hold();
    test_queue();
    test_random();
    test_err();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
